// File: rtl/iface_byte_tx.sv
// iface_byte_tx: FIFO-buffered byte transmitter with frame delimiting and idle gaps; IFACE_TX_PARITY_EN adds parity
module iface_byte_tx #(
  parameter int DEPTH = 4,
  parameter int IFG = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] frame_count,
`ifdef IFACE_TX_PARITY_EN
  input  logic        in_parity_err_inject,
  output logic        out_parity,
`endif
  output logic        busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef IFACE_TX_PARITY_EN
  localparam int W = 10;
`else
  localparam int W = 9;
`endif
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t state, state_n;
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] head, entry;
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] count, count_n;
  logic [3:0] gcnt, gcnt_n;
  logic push, pop;
  assign in_ready = count != CW'(DEPTH);
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  assign head = mem[rp];
  assign out_valid = state == SEND;
  assign out_data = out_valid ? head[7:0] : 8'd0;
  assign out_last = out_valid && head[8];
  assign busy = count != '0 || state == GAP;
  assign count_n = count + CW'(push) - CW'(pop);
`ifdef IFACE_TX_PARITY_EN
  assign entry = {^in_data ^ in_parity_err_inject, in_last, in_data};
  assign out_parity = out_valid && head[9];
`else
  assign entry = {in_last, in_data};
`endif
  // next state looks at count_n so a push into an empty FIFO enters SEND at that same edge
  always_comb begin
    state_n = state;
    gcnt_n = gcnt;
    if (state == GAP) begin
      gcnt_n = gcnt - 4'd1;
      if (gcnt == 4'd1) state_n = count_n != '0 ? SEND : IDLE;
    end else if (pop && out_last && IFG != 0) begin
      state_n = GAP;
      gcnt_n = 4'(IFG);
    end else state_n = count_n != '0 ? SEND : IDLE;
  end
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= entry;
    if (rst) begin
      state <= IDLE;
      gcnt <= '0;
      wp <= '0;
      rp <= '0;
      count <= '0;
      frame_count <= '0;
    end else begin
      state <= state_n;
      gcnt <= gcnt_n;
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      count <= count_n;
      if (pop && out_last) frame_count <= frame_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_iface_byte_tx.sv
// tb_iface_byte_tx: randomized scoreboard bench; second instance with zero gap exercises frame_count wrap
module tb_iface_byte_tx;
  localparam int DEPTH = 4;
  localparam int IFG = 2;
  typedef struct {logic [7:0] d; logic l; logic p;} ent_t;
  logic clk = 0, rst = 1, rst1 = 1;
  logic [7:0] in_data = 0, out_data, out_data1;
  logic in_last = 0, in_valid = 0, out_ready = 0, inj = 0;
  logic in_ready, out_last, out_valid, busy, in_ready1, out_last1, out_valid1, busy1;
  logic [15:0] frame_count, fc1;
`ifdef IFACE_TX_PARITY_EN
  logic out_parity, out_parity1;
`endif
  int checks = 0, errors = 0, n1 = 0, gap = 0;
  logic go = 0, w_done = 0, pv, acc, lst;
  logic [15:0] fc = 0;
  logic mq [$];
  ent_t sb [$];
  ent_t e;
  always #5 clk = ~clk;
  iface_byte_tx #(.DEPTH(DEPTH), .IFG(IFG)) u0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_last(in_last), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .frame_count(frame_count),
`ifdef IFACE_TX_PARITY_EN
    .in_parity_err_inject(inj), .out_parity(out_parity),
`endif
    .busy(busy));
  iface_byte_tx #(.DEPTH(DEPTH), .IFG(0)) u1 (
    .clk(clk), .rst(rst1), .in_data(8'h5a), .in_last(1'b1), .in_valid(1'b1),
    .in_ready(in_ready1), .out_data(out_data1), .out_last(out_last1), .out_valid(out_valid1),
    .out_ready(1'b1), .frame_count(fc1),
`ifdef IFACE_TX_PARITY_EN
    .in_parity_err_inject(1'b0), .out_parity(out_parity1),
`endif
    .busy(busy1));
  task automatic chk(input string n, input int a, input int x);
    checks++;
    if (a != x) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", n, a, x, $time);
    end
  endtask
  task automatic cyc(input logic [7:0] d, input logic l, input logic v, input logic r);
    in_data = d; in_last = l; in_valid = v; out_ready = r;
    @(posedge clk); #1;
  endtask
  // reference model: queue occupancy plus a remaining-gap counter, updated at each edge
  initial forever begin
    @(posedge clk);
    if (rst) begin
      mq.delete(); sb.delete(); gap = 0; fc = 0;
    end else begin
      pv = mq.size() > 0 && gap == 0;
      acc = in_valid && mq.size() != DEPTH;
      if (pv && out_ready) begin
        lst = mq.pop_front();
        if (lst) begin fc++; gap = IFG; end
      end else if (gap > 0) gap--;
      if (acc) begin
        mq.push_back(in_last);
        sb.push_back('{in_data, in_last, ^in_data ^ inj});
      end
    end
  end
  initial forever begin
    @(posedge clk);
    if (rst1) n1 = 0; else if (out_valid1) n1++;
  end
  initial forever begin
    @(negedge clk);
    if (go) begin
      chk("out_valid", int'(out_valid), int'(mq.size() > 0 && gap == 0));
      chk("in_ready", int'(in_ready), int'(mq.size() != DEPTH));
      chk("busy", int'(busy), int'(mq.size() > 0 || gap > 0));
      chk("frame_count", int'(frame_count), int'(fc));
      if (out_valid) begin
        if (sb.size() == 0) chk("sb_empty", 1, 0);
        else begin
          e = sb[0];
          chk("out_data", int'(out_data), int'(e.d));
          chk("out_last", int'(out_last), int'(e.l));
`ifdef IFACE_TX_PARITY_EN
          chk("out_parity", int'(out_parity), int'(e.p));
`endif
          if (out_ready) void'(sb.pop_front());
        end
      end else begin
        chk("idle_data", int'(out_data), 0);
        chk("idle_last", int'(out_last), 0);
      end
    end
    if (!rst1 && !w_done && (n1 % 4096 == 0 || n1 >= 65535)) begin
      chk("wrap_fc", int'(fc1), n1 % 65536);
      if (n1 >= 65537) w_done = 1;
    end
  end
  initial begin
    @(posedge clk); #1 go = 1;
    @(posedge clk); #1 rst = 0; rst1 = 0;
    cyc(8'ha5, 1, 1, 1);
    repeat (5) cyc(0, 0, 0, 1);
    for (int i = 1; i <= 5; i++) cyc(8'(i), i == 4, 1, 0);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(8'(8'h30 + i), i % 3 == 2, 1, 1);
    repeat (8) cyc(0, 0, 0, 1);
    cyc(8'h10, 0, 1, 0);
    cyc(8'h11, 1, 1, 0);
    cyc(8'h20, 1, 1, 0);
    repeat (10) cyc(0, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      inj = $urandom_range(0, 3) == 0;
      cyc(8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0);
    end
    inj = 0;
    repeat (10) cyc(0, 0, 0, 1);
    cyc(8'h01, 0, 1, 0);
    cyc(8'h02, 0, 1, 1);
    rst = 1;
    cyc(0, 0, 0, 0);
    rst = 0;
    repeat (5) cyc(0, 0, 0, 1);
    for (int i = 0; i < 70000 && !w_done; i++) @(posedge clk);
    if (!w_done) chk("wrap_timeout", 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/iface_byte_tx.md
# iface_byte_tx

Byte-stream transmitter that drives the 8-bit data bundle consumed by interface-port receivers. Accepts bytes from an upstream producer through a small FIFO. Presents them to the downstream receiver with a valid/ready handshake and frame delimiting. Enforces a programmable idle gap between frames. Used by the interface-port regression benches as the driving end of the link.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `IFG`, default 2: idle cycles forced after each frame's last byte; 0..15.
- `clk` input, 1 bit: clock; all state updates on the rising edge.
- `rst` input, 1 bit: reset, synchronous, active-high.
- `in_data` input, 8 bits: upstream byte.
- `in_last` input, 1 bit: marks `in_data` as the final byte of a frame.
- `in_valid` input, 1 bit: upstream byte present.
- `in_ready` output, 1 bit: FIFO can accept this cycle.
- `out_data` output, 8 bits: byte to the receiver.
- `out_last` output, 1 bit: `out_data` is the frame's final byte.
- `out_valid` output, 1 bit: `out_data`/`out_last` are valid.
- `out_ready` input, 1 bit: receiver accepts this cycle.
- `frame_count` output, 16 bits: frames completed since reset.
- `busy` output, 1 bit: FIFO non-empty or GAP state active.

## Operation
- **Push:** occurs when `in_valid && in_ready`. Writes {`in_last`, `in_data`} at the write pointer. `in_ready` = (count != `DEPTH`), combinational from registered count only.
- **Pop:** occurs when `out_valid && out_ready`. Advances the read pointer.
- **Outputs from FIFO head:** `out_data`/`out_last` = head entry. When `out_valid` = 0, both are driven 0.
- **No bypass:**
  - A byte pushed at edge N is poppable no earlier than the cycle after edge N.
  - A push into an empty FIFO never appears on `out_data` in the same cycle.
- **Simultaneous push and pop:** allowed whenever `in_ready` = 1; count unchanged. A full FIFO blocks the push even if a pop occurs that cycle.
- **Pointers:** wrap modulo `DEPTH`. Count is log2(`DEPTH`)+1 bits.
- **State machine:**
  - IDLE: FIFO empty. `out_valid` = 0. Goes to SEND when count becomes non-zero.
  - SEND: `out_valid` = 1.
    - Pop with `out_last` = 1 and `IFG` > 0 → GAP, gap counter loaded with `IFG`.
    - Pop with `out_last` = 1 and `IFG` = 0 → SEND if bytes remain, else IDLE.
    - Otherwise, if the FIFO is emptied → IDLE.
  - GAP: `out_valid` = 0 and pushes still accepted. Counter decrements each cycle. On reaching 1 → SEND if count != 0, else IDLE.
- **Frame count:** `frame_count` increments on every pop with `out_last` = 1 and wraps 0xFFFF → 0x0000.
- **Handshake stability:** once `out_valid` rises, `out_data`/`out_last`/`out_valid` hold until the pop. The block never withdraws a presented byte.

## Timing
- **Reset values:**
  - `in_ready` = 1; `out_valid` = 0; `out_data` = 0; `out_last` = 0.
  - `frame_count` = 0; `busy` = 0.
  - State IDLE; pointers and count 0. FIFO contents are don't-care.
- **Latency:** push at edge N → `out_valid` high in cycle N+1 (state SEND entered at edge N).
- **Throughput:** one byte per cycle within a frame while `out_ready` = 1.
- **Frame spacing:** exactly `IFG` cycles of `out_valid` = 0 between a last-byte pop and the next frame's first byte. This holds even if the FIFO is full.
- **Mid-operation reset:** `rst` at any edge discards FIFO contents and gap state. Outputs take reset values the following cycle; no partial frame is resumed.

## Configuration
- **`IFACE_TX_PARITY_EN` defined:**
  - Adds output `out_parity` (1 bit) = XOR of `out_data` bits (even parity), 0 when `out_valid` = 0.
  - Also adds input `in_parity_err_inject` (1 bit). When it is high at push, the stored parity is inverted for that entry.
  - FIFO width becomes 10 bits.
- **Undefined:** neither port exists; FIFO width 9 bits; behaviour otherwise identical.

## Test plan
- **Reset then single byte:** push 0xA5 with `in_last` = 1, `out_ready` = 1 → `out_valid` high one cycle later with 0xA5, `out_last` = 1; `frame_count` 0→1; then 2 idle cycles (`IFG` = 2).
- **Fill to full:** `out_ready` = 0, push 0x01..0x04 → `in_ready` low after the 4th push; a 5th offered byte is not accepted. Release `out_ready` → 0x01..0x04 appear in order.
- **Simultaneous push/pop at full:** full FIFO, `in_valid` = 1, `out_ready` = 1 → first cycle pops only. Following cycles push and pop together, count steady at 3.
- **Back-to-back frames:** frames {0x10, 0x11 last} and {0x20 last} queued → exactly 2 cycles `out_valid` = 0 between 0x11 and 0x20; `frame_count` = 2.
- **Wrap and reset:** preload `frame_count` to 0xFFFF via 65535 single-byte frames → next last-byte pop gives 0x0000. Assert `rst` mid-frame → `out_valid` 0 next cycle, `busy` 0.
- **With `IFACE_TX_PARITY_EN`:** push 0x07 → `out_parity` = 1. Push 0x03 with `in_parity_err_inject` = 1 → `out_parity` = 1.
